// File: rtl/pc_next_unit.sv
// -----------------------------------------------------------------------------
// pc_next_unit
//   Program-counter unit for the MIPS fetch stage. Holds the PC register and
//   picks the next PC from the sequential, BEQ/BNE branch, J/JAL and JR
//   targets. A small return address stack (RAS) predicts JR $ra targets. A
//   valid/ready handshake with instruction fetch gates every PC advance.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   pc_ready     fetch accepts the current pc this cycle
//   pc_valid     pc is a valid fetch address (rises one edge after reset)
//   pc           current program counter (registered)
//   branch/bne/zero/imm_ext   conditional branch controls and word offset
//   jump/jal/jump_idx         J and JAL controls and instruction index
//   jr/jr_is_ra/jr_addr       JR controls and register-file target
//   ras_empty    RAS holds no entries
//   taken_count  saturating count of accepted non-sequential updates
// -----------------------------------------------------------------------------
module pc_next_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_ready,
  output logic             pc_valid,
  output logic [XLEN-1:0]  pc,
  input  logic             branch,
  input  logic             bne,
  input  logic             zero,
  input  logic [XLEN-1:0]  imm_ext,
  input  logic             jump,
  input  logic             jal,
  input  logic [25:0]      jump_idx,
  input  logic             jr,
  input  logic             jr_is_ra,
  input  logic [XLEN-1:0]  jr_addr,
  output logic             ras_empty,
  output logic [CNT_W-1:0] taken_count
);

  localparam int             PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] RAS_FULL = (PTR_W+1)'(RAS_DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic [XLEN-1:0]  ras_mem_q [RAS_DEPTH];
  // ras_ptr_q is the next write slot; the top of stack sits one below it.
  logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
  logic [PTR_W:0]   ras_cnt_q, ras_cnt_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;

  logic             accept;
  logic             br_taken;
  logic             redirect;
  logic             ras_push;
  logic [XLEN-1:0]  pc_plus_4;
  logic [XLEN-1:0]  br_tgt;
  logic [XLEN-1:0]  j_tgt;
  logic [XLEN-1:0]  ras_top;

  assign accept    = pc_valid_q & pc_ready;
  assign br_taken  = branch & (zero ^ bne);
  assign pc_plus_4 = pc_q + XLEN'(4);
  assign br_tgt    = pc_plus_4 + (imm_ext << 2);
  assign j_tgt     = {pc_plus_4[XLEN-1:28], jump_idx, 2'b00};
  assign ras_top   = ras_mem_q[ras_ptr_q - PTR_W'(1)];
  assign ras_empty = (ras_cnt_q == '0);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    pc_d          = pc_q;
    pc_valid_d    = 1'b1;
    ras_ptr_d     = ras_ptr_q;
    ras_cnt_d     = ras_cnt_q;
    taken_count_d = taken_count_q;
    ras_push      = 1'b0;
    redirect      = 1'b0;

    if (accept) begin
      redirect = 1'b1;
      if (jr) begin
        // jr outranks jal, so a simultaneous jal never pushes.
        if (jr_is_ra && !ras_empty) begin
          pc_d      = ras_top;
          ras_ptr_d = ras_ptr_q - PTR_W'(1);
          ras_cnt_d = ras_cnt_q - 1'b1;
        end else begin
          pc_d = jr_addr;
        end
      end else if (jump || jal) begin
        pc_d = j_tgt;
        if (jal) begin
          // A full stack overwrites its oldest slot: the pointer wraps and
          // the count pins at RAS_DEPTH.
          ras_push  = 1'b1;
          ras_ptr_d = ras_ptr_q + PTR_W'(1);
          if (ras_cnt_q != RAS_FULL) ras_cnt_d = ras_cnt_q + 1'b1;
        end
      end else if (br_taken) begin
        pc_d = br_tgt;
      end else begin
        pc_d     = pc_plus_4;
        redirect = 1'b0;
      end

      if (redirect && (taken_count_q != '1)) taken_count_d = taken_count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_VECTOR;
      pc_valid_q    <= 1'b0;
      ras_ptr_q     <= '0;
      ras_cnt_q     <= '0;
      taken_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      pc_valid_q    <= pc_valid_d;
      ras_ptr_q     <= ras_ptr_d;
      ras_cnt_q     <= ras_cnt_d;
      taken_count_q <= taken_count_d;
    end
  end

  // NOTE: the RAS storage is deliberately not reset; ras_cnt_q guards every
  // read, so stale entries are never observed and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (ras_push) ras_mem_q[ras_ptr_q] <= pc_plus_4;
  end

  assign pc          = pc_q;
  assign pc_valid    = pc_valid_q;
  assign taken_count = taken_count_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_next_unit
//   Self-checking bench for pc_next_unit. A behavioural model (PC variable,
//   a bounded queue as the return stack, an integer counter) advances in step
//   with each clock edge; directed scenarios and a randomized run compare the
//   DUT against it and against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_pc_next_unit;

  localparam int XLEN      = 32;
  localparam int RAS_DEPTH = 4;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             pc_ready;
  logic             pc_valid;
  logic [XLEN-1:0]  pc;
  logic             branch, bne, zero;
  logic [XLEN-1:0]  imm_ext;
  logic             jump, jal;
  logic [25:0]      jump_idx;
  logic             jr, jr_is_ra;
  logic [XLEN-1:0]  jr_addr;
  logic             ras_empty;
  logic [CNT_W-1:0] taken_count;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state.
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_ras[$];
  int          m_cnt;

  pc_next_unit #(
    .XLEN(XLEN), .RESET_VECTOR(32'h0), .RAS_DEPTH(RAS_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .pc_ready(pc_ready), .pc_valid(pc_valid), .pc(pc),
    .branch(branch), .bne(bne), .zero(zero), .imm_ext(imm_ext),
    .jump(jump), .jal(jal), .jump_idx(jump_idx),
    .jr(jr), .jr_is_ra(jr_is_ra), .jr_addr(jr_addr),
    .ras_empty(ras_empty), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_ras.delete();
    m_cnt   = 0;
  endtask

  // Apply one clock edge's worth of architectural effect to the model.
  task automatic model_edge();
    logic [31:0] seq;
    bit          nonseq;
    seq    = m_pc + 32'd4;
    nonseq = 1'b1;
    if (!m_valid) begin
      m_valid = 1'b1;
    end else if (pc_ready) begin
      if (jr) begin
        if (jr_is_ra && m_ras.size() > 0) m_pc = m_ras.pop_back();
        else                              m_pc = jr_addr;
      end else if (jump || jal) begin
        if (jal) begin
          m_ras.push_back(seq);
          if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
        m_pc = (seq & 32'hF000_0000) | ({6'd0, jump_idx} << 2);
      end else if (branch && (zero != bne)) begin
        m_pc = seq + (imm_ext << 2);
      end else begin
        m_pc   = seq;
        nonseq = 1'b0;
      end
      if (nonseq && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  // One rising edge; the model follows it and outputs are settled 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    pc_ready = 1'b1;
    branch = 1'b0; bne = 1'b0; zero = 1'b0; imm_ext = '0;
    jump = 1'b0; jal = 1'b0; jump_idx = '0;
    jr = 1'b0; jr_is_ra = 1'b0; jr_addr = '0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'd0; exp_pc[1] = 32'd4; exp_pc[2] = 32'd8; exp_pc[3] = 32'd12;
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    n_cmp++;
    if (pc !== 32'h0 || pc_valid !== 1'b0 || ras_empty !== 1'b1 || taken_count !== '0) begin
      n_err++;
      $display("FAIL reset_state: pc=%h valid=%b ras_empty=%b cnt=%0d, want 0/0/1/0",
               pc, pc_valid, ras_empty, taken_count);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (pc_valid !== 1'b0) begin
      n_err++;
      $display("FAIL valid_after_release: pc_valid=%b, want 0", pc_valid);
    end
    cycle();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (pc !== exp_pc[i] || pc_valid !== 1'b1) begin
        n_err++;
        $display("FAIL seq_pc%0d: pc=%h valid=%b, want %h/1", i, pc, pc_valid, exp_pc[i]);
      end
      cycle();
    end
  endtask

  task automatic test_branch();
    int cnt0;
    // Steer to pc=0x100 with a jump (index 0x40).
    idle(); jump = 1'b1; jump_idx = 26'h40; cycle();
    n_cmp++;
    if (pc !== 32'h100) begin
      n_err++; $display("FAIL br_setup: pc=%h, want 00000100", pc);
    end
    cnt0 = m_cnt;
    idle(); branch = 1'b1; zero = 1'b1; imm_ext = 32'hFFFF_FFFE; cycle();
    n_cmp++;
    if (pc !== 32'hFC || taken_count !== CNT_W'(cnt0 + 1)) begin
      n_err++;
      $display("FAIL beq_taken: pc=%h cnt=%0d, want 000000fc/%0d", pc, taken_count, cnt0 + 1);
    end
    idle(); jump = 1'b1; jump_idx = 26'h40; cycle();
    cnt0 = m_cnt;
    idle(); branch = 1'b1; bne = 1'b1; zero = 1'b1; imm_ext = 32'hFFFF_FFFE; cycle();
    n_cmp++;
    if (pc !== 32'h104 || taken_count !== CNT_W'(cnt0)) begin
      n_err++;
      $display("FAIL bne_not_taken: pc=%h cnt=%0d, want 00000104/%0d", pc, taken_count, cnt0);
    end
  endtask

  task automatic test_jal_jr();
    idle(); jr = 1'b1; jr_addr = 32'h0040_0010; cycle();
    n_cmp++;
    if (pc !== 32'h0040_0010) begin
      n_err++; $display("FAIL jr_plain: pc=%h, want 00400010", pc);
    end
    // Index 0x100100 shifted by 2 lands on 0x0040_0400 within the same 256 MB region.
    idle(); jal = 1'b1; jump_idx = 26'h10_0100; cycle();
    n_cmp++;
    if (pc !== 32'h0040_0400 || ras_empty !== 1'b0) begin
      n_err++;
      $display("FAIL jal: pc=%h ras_empty=%b, want 00400400/0", pc, ras_empty);
    end
    idle(); jr = 1'b1; jr_is_ra = 1'b1; jr_addr = 32'h0000_DEAD; cycle();
    n_cmp++;
    if (pc !== 32'h0040_0014 || ras_empty !== 1'b1) begin
      n_err++;
      $display("FAIL jr_ra: pc=%h ras_empty=%b, want 00400014/1", pc, ras_empty);
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] rets [RAS_DEPTH+1];
    n_cmp++;
    if (ras_empty !== 1'b1) begin
      n_err++; $display("FAIL ras_start_empty: ras_empty=%b, want 1", ras_empty);
    end
    for (int i = 0; i <= RAS_DEPTH; i++) begin
      idle(); jal = 1'b1; jump_idx = 26'(32'h1000 + 32'h40 * i);
      rets[i] = m_pc + 32'd4;
      cycle();
    end
    for (int i = 0; i < RAS_DEPTH; i++) begin
      idle(); jr = 1'b1; jr_is_ra = 1'b1; jr_addr = 32'h0BAD_0000; cycle();
      n_cmp++;
      if (pc !== rets[RAS_DEPTH - i]) begin
        n_err++;
        $display("FAIL ras_pop%0d: pc=%h, want %h", i, pc, rets[RAS_DEPTH - i]);
      end
    end
    n_cmp++;
    if (ras_empty !== 1'b1) begin
      n_err++; $display("FAIL ras_drained: ras_empty=%b, want 1", ras_empty);
    end
    idle(); jr = 1'b1; jr_is_ra = 1'b1; jr_addr = 32'h0BAD_0000; cycle();
    n_cmp++;
    if (pc !== 32'h0BAD_0000 || ras_empty !== 1'b1) begin
      n_err++;
      $display("FAIL ras_pop_empty: pc=%h ras_empty=%b, want 0bad0000/1", pc, ras_empty);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc0;
    logic [CNT_W-1:0] cnt0;
    pc0  = m_pc;
    cnt0 = CNT_W'(m_cnt);
    idle(); pc_ready = 1'b0; jump = 1'b1; jump_idx = 26'h1234;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (pc !== pc0 || taken_count !== cnt0) begin
        n_err++;
        $display("FAIL stall%0d: pc=%h cnt=%0d, want %h/%0d", i, pc, taken_count, pc0, cnt0);
      end
    end
    pc_ready = 1'b1; cycle();
    n_cmp++;
    if (pc !== ((pc0 + 32'd4) & 32'hF000_0000 | 32'h48D0)) begin
      n_err++;
      $display("FAIL stall_release: pc=%h, want %h", pc, (pc0 + 32'd4) & 32'hF000_0000 | 32'h48D0);
    end
  endtask

  task automatic test_saturation();
    idle(); jump = 1'b1; jump_idx = 26'h200;
    for (int i = 0; i < CNT_MAX + 4; i++) cycle();
    n_cmp++;
    if (taken_count !== CNT_W'(CNT_MAX)) begin
      n_err++; $display("FAIL cnt_saturate: cnt=%0d, want %0d", taken_count, CNT_MAX);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      pc_ready = ($urandom_range(0, 3) != 0);
      branch   = ($urandom_range(0, 3) == 0);
      bne      = $urandom_range(0, 1) == 1;
      zero     = $urandom_range(0, 1) == 1;
      imm_ext  = 32'($signed($urandom_range(0, 64)) - 32);
      jump     = ($urandom_range(0, 9) == 0);
      jal      = ($urandom_range(0, 6) == 0);
      jump_idx = 26'($urandom);
      jr       = ($urandom_range(0, 7) == 0);
      jr_is_ra = ($urandom_range(0, 3) != 0);
      jr_addr  = $urandom & 32'hFFFF_FFFC;
      cycle();
      n_cmp++;
      if (pc !== m_pc || pc_valid !== m_valid || ras_empty !== (m_ras.size() == 0) ||
          taken_count !== CNT_W'(m_cnt)) begin
        n_err++;
        if (bad < 10)
          $display("FAIL rand%0d: pc=%h valid=%b ras_empty=%b cnt=%0d, want %h/%b/%b/%0d",
                   i, pc, pc_valid, ras_empty, taken_count, m_pc, m_valid,
                   m_ras.size() == 0, m_cnt);
        bad++;
      end
    end
  endtask

  task automatic test_async_reset();
    idle(); jal = 1'b1; jump_idx = 26'h3000; cycle();
    idle();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (pc !== 32'h0 || ras_empty !== 1'b1 || taken_count !== '0 || pc_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: pc=%h ras_empty=%b cnt=%0d valid=%b, want 0/1/0/0",
               pc, ras_empty, taken_count, pc_valid);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    cycle();
    cycle();
    n_cmp++;
    if (pc !== 32'd4 || pc_valid !== 1'b1) begin
      n_err++; $display("FAIL post_reset_run: pc=%h valid=%b, want 00000004/1", pc, pc_valid);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jal_jr();
    test_ras_overflow();
    test_stall();
    test_saturation();
    test_async_reset();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
